// File: rtl/exec_pkg.sv
// Shared opcode encodings for the execute stage.
// Imported by the ALU and the stage top.
package exec_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SHL = 3'b001;
  localparam logic [OP_W-1:0] OP_MIN = 3'b010;
  localparam logic [OP_W-1:0] OP_MAX = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_SHR = 3'b101;
  localparam logic [OP_W-1:0] OP_OR  = 3'b110;
  localparam logic [OP_W-1:0] OP_AND = 3'b111;

endpackage

// File: rtl/exec_if.sv
// Operand-in / result-out handshake bundle
// for the execute stage.
interface exec_if #(
  parameter int WIDTH = 8
);
  import exec_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_zero;
  logic [OP_W-1:0]  out_op;

  modport master (
    output in_valid, in_op, in_a, in_b,
    output out_ready,
    input  in_ready,
    input  out_valid, out_result,
    input  out_carry, out_zero, out_op
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b,
    input  out_ready,
    output in_ready,
    output out_valid, out_result,
    output out_carry, out_zero, out_op
  );

endinterface

// File: rtl/exec_alu.sv
// Combinational ALU: (a, b, op) -> (result, carry).
// Shift amounts at or beyond WIDTH yield zero.
module exec_alu
  import exec_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);

  localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);

  logic [WIDTH:0] sum;
  logic           big_shift;

  assign sum       = {1'b0, a_i} + {1'b0, b_i};
  assign big_shift = (b_i >= WLIM);

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    unique case (1'b1)
      (op_i == OP_ADD): begin
        result_o = sum[WIDTH-1:0];
        carry_o  = sum[WIDTH];
      end
      (op_i == OP_SHL):
        result_o = big_shift ? '0 : (a_i << b_i);
      (op_i == OP_MIN):
        result_o = (a_i < b_i) ? a_i : b_i;
      (op_i == OP_MAX):
        result_o = (a_i > b_i) ? a_i : b_i;
      (op_i == OP_XOR):
        result_o = a_i ^ b_i;
      (op_i == OP_SHR):
        result_o = big_shift ? '0 : (a_i >> b_i);
      (op_i == OP_OR):
        result_o = a_i | b_i;
      (op_i == OP_AND):
        result_o = a_i & b_i;
      default: begin
        result_o = '0;
        carry_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: one ALU op per accepted operand pair,
// result held in a single-entry output register.
module execute_unit
  import exec_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter bit AUTO_OP = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  exec_if.slave       bus,
  output logic [15:0] op_count
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [OP_W-1:0]  auto_q, auto_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             accept;
  logic [OP_W-1:0]  op_sel;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign op_sel       = AUTO_OP ? auto_q : bus.in_op;

  exec_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a_i      (bus.in_a),
    .b_i      (bus.in_b),
    .op_i     (op_sel),
    .result_o (alu_res),
    .carry_o  (alu_carry)
  );

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    op_d     = op_q;
    auto_d   = auto_q;
    cnt_d    = cnt_q;
    if (accept) begin
      valid_d  = 1'b1;
      result_d = alu_res;
      carry_d  = alu_carry;
      zero_d   = (alu_res == '0);
      op_d     = op_sel;
      auto_d   = auto_q + 1'b1;
      cnt_d    = cnt_q + 16'd1;
    end else if (bus.out_ready) begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      op_q     <= '0;
      auto_q   <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      op_q     <= op_d;
      auto_q   <= auto_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_result = result_q;
  assign bus.out_carry  = carry_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_op     = op_q;
  assign op_count       = cnt_q;

endmodule
